// File: rtl/fwrisc_mem_arb.sv
// Arbitrates the fetch and load/store masters onto one registered memory port.
// One transaction at a time, with a watchdog that aborts stalled accesses.
module fwrisc_mem_arb #(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ivalid,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    output logic        iready,
    input  logic        dvalid,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    input  logic        dwrite,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        mvalid,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mwstb,
    output logic        mwrite,
    input  logic [31:0] mrdata,
    input  logic        mready,
    output logic        grant,
    output logic        bus_err,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WD_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic             last_owner;
    logic [CNT_W-1:0] wd_cnt;
    logic             owner;
    logic             timeout;
    logic             done;

    // Data wins when it is the only requester, under fixed priority, or on its round-robin turn.
    assign owner = dvalid && (!ivalid || (PRIORITY_MODE != 0) || !last_owner);

    assign timeout = (TIMEOUT_CYCLES > 0) && (state == BUSY) && !mready && (wd_cnt == WD_LAST);
    assign done    = (state == BUSY) && (mready || timeout);

    assign iready = done && !grant;
    assign dready = done && grant;
    assign idata  = (iready && mready) ? mrdata : 32'd0;
    assign drdata = (dready && mready) ? mrdata : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            wd_cnt     <= '0;
            grant      <= 1'b0;
            mvalid     <= 1'b0;
            maddr      <= 32'd0;
            mwdata     <= 32'd0;
            mwstb      <= 4'd0;
            mwrite     <= 1'b0;
            bus_err    <= 1'b0;
            err_addr   <= 32'd0;
        end else begin
            if (timeout) begin
                bus_err  <= 1'b1;
                err_addr <= maddr;
            end else if (err_clr) begin
                bus_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ivalid || dvalid) begin
                        grant  <= owner;
                        mvalid <= 1'b1;
                        wd_cnt <= '0;
                        state  <= BUSY;
                        // Fetches are always issued as plain reads.
                        if (owner) begin
                            maddr  <= daddr;
                            mwdata <= dwdata;
                            mwstb  <= dwstb;
                            mwrite <= dwrite;
                        end else begin
                            maddr  <= iaddr;
                            mwdata <= 32'd0;
                            mwstb  <= 4'd0;
                            mwrite <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (mready) begin
                        mvalid     <= 1'b0;
                        mwrite     <= 1'b0;
                        mwstb      <= 4'd0;
                        last_owner <= grant;
                        state      <= IDLE;
                    end else if (timeout) begin
                        mvalid <= 1'b0;
                        mwrite <= 1'b0;
                        mwstb  <= 4'd0;
                        state  <= IDLE;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_mem_arb.sv
// Directed bench for fwrisc_mem_arb: u0 is round-robin with a short watchdog,
// u1 is fixed-priority; each has its own valid/mready controls.
module tb_fwrisc_mem_arb;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ivalid = 1'b0, dvalid = 1'b0, mready = 1'b0, err_clr = 1'b0;
    logic        ivalid1 = 1'b0, dvalid1 = 1'b0, mready1 = 1'b0;
    logic [31:0] iaddr = 32'd0, daddr = 32'd0, dwdata = 32'd0, mrdata = 32'd0;
    logic [3:0]  dwstb = 4'd0;
    logic        dwrite = 1'b0;

    logic [31:0] idata, drdata, maddr, mwdata, err_addr;
    logic        iready, dready, mvalid, mwrite, grant, bus_err;
    logic [3:0]  mwstb;
    logic [31:0] idata1, drdata1, maddr1, mwdata1, err_addr1;
    logic        iready1, dready1, mvalid1, mwrite1, grant1, bus_err1;
    logic [3:0]  mwstb1;

    int nchk = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    fwrisc_mem_arb #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) u0 (
        .clock(clock), .reset(reset),
        .ivalid(ivalid), .iaddr(iaddr), .idata(idata), .iready(iready),
        .dvalid(dvalid), .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
        .drdata(drdata), .dready(dready),
        .mvalid(mvalid), .maddr(maddr), .mwdata(mwdata), .mwstb(mwstb), .mwrite(mwrite),
        .mrdata(mrdata), .mready(mready),
        .grant(grant), .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
    );

    fwrisc_mem_arb #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(16)) u1 (
        .clock(clock), .reset(reset),
        .ivalid(ivalid1), .iaddr(iaddr), .idata(idata1), .iready(iready1),
        .dvalid(dvalid1), .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
        .drdata(drdata1), .dready(dready1),
        .mvalid(mvalid1), .maddr(maddr1), .mwdata(mwdata1), .mwstb(mwstb1), .mwrite(mwrite1),
        .mrdata(mrdata), .mready(mready1),
        .grant(grant1), .bus_err(bus_err1), .err_addr(err_addr1), .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_owner;

        // Reset state
        #12;
        chk("rst_mvalid", 32'(mvalid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_maddr", maddr, 32'd0);
        chk("rst_readies", {30'd0, iready, dready}, 32'd0);
        reset = 1'b1;

        // Fetch only, mready on the third BUSY cycle
        tick();
        ivalid = 1'b1; iaddr = 32'h100;
        tick();
        chk("f_mvalid", 32'(mvalid), 32'd1);
        chk("f_maddr", maddr, 32'h100);
        chk("f_mwrite", 32'(mwrite), 32'd0);
        chk("f_mwstb", 32'(mwstb), 32'd0);
        chk("f_grant", 32'(grant), 32'd0);
        chk("f_iready_early", 32'(iready), 32'd0);
        tick();
        chk("f_iready_wait", 32'(iready), 32'd0);
        tick();
        mready = 1'b1; mrdata = 32'h13;
        #1;
        chk("f_iready", 32'(iready), 32'd1);
        chk("f_idata", idata, 32'h13);
        chk("f_dready", 32'(dready), 32'd0);
        chk("f_drdata", drdata, 32'd0);
        tick();
        ivalid = 1'b0;
        #1;
        chk("f_mvalid_done", 32'(mvalid), 32'd0);
        chk("f_iready_done", 32'(iready), 32'd0);
        chk("f_idata_done", idata, 32'd0);
        mready = 1'b0;

        // mready while idle produces no ready pulse
        tick();
        mready = 1'b1;
        #1;
        chk("idle_mready", {30'd0, iready, dready}, 32'd0);
        mready = 1'b0;

        // Store only
        tick();
        dvalid = 1'b1; daddr = 32'h2004; dwdata = 32'hAB; dwstb = 4'b0010; dwrite = 1'b1;
        tick();
        chk("s_grant", 32'(grant), 32'd1);
        chk("s_maddr", maddr, 32'h2004);
        chk("s_mwrite", 32'(mwrite), 32'd1);
        chk("s_mwstb", 32'(mwstb), 32'b0010);
        chk("s_mwdata", mwdata, 32'hAB);
        mready = 1'b1; mrdata = 32'h55;
        #1;
        chk("s_dready", 32'(dready), 32'd1);
        chk("s_iready", 32'(iready), 32'd0);
        tick();
        dvalid = 1'b0; mready = 1'b0; dwrite = 1'b0; dwstb = 4'd0;
        #1;
        chk("s_mvalid_done", 32'(mvalid), 32'd0);
        chk("s_mwrite_done", 32'(mwrite), 32'd0);
        chk("s_grant_hold", 32'(grant), 32'd1);

        // Round-robin with both masters held valid
        iaddr = 32'h200; daddr = 32'h300; ivalid = 1'b1; dvalid = 1'b1; mrdata = 32'hC0DE;
        exp_owner = 1'b0;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(exp_owner));
            chk("rr_maddr", maddr, exp_owner ? 32'h300 : 32'h200);
            mready = 1'b1;
            #1;
            chk("rr_ready", {30'd0, iready, dready}, exp_owner ? 32'd1 : 32'd2);
            tick();
            mready = 1'b0;
            #1;
            chk("rr_idle_gap", 32'(mvalid), 32'd0);
            exp_owner = ~exp_owner;
        end
        ivalid = 1'b0; dvalid = 1'b0;

        // Fixed priority on u1: data first, fetch second
        iaddr = 32'h400; daddr = 32'h500; dwrite = 1'b1; dwdata = 32'h1234; dwstb = 4'hF;
        ivalid1 = 1'b1; dvalid1 = 1'b1;
        tick();
        chk("p_grant_d", 32'(grant1), 32'd1);
        chk("p_maddr_d", maddr1, 32'h500);
        daddr = 32'hDEAD;
        tick();
        chk("p_maddr_hold", maddr1, 32'h500);
        chk("p_mwdata_hold", mwdata1, 32'h1234);
        mready1 = 1'b1;
        #1;
        chk("p_dready", 32'(dready1), 32'd1);
        chk("p_iready_wait", 32'(iready1), 32'd0);
        tick();
        dvalid1 = 1'b0; mready1 = 1'b0; dwrite = 1'b0; dwstb = 4'd0;
        #1;
        chk("p_idle_gap", 32'(mvalid1), 32'd0);
        tick();
        chk("p_grant_f", 32'(grant1), 32'd0);
        chk("p_maddr_f", maddr1, 32'h400);
        chk("p_mwrite_f", 32'(mwrite1), 32'd0);
        mready1 = 1'b1; mrdata = 32'h00000013;
        #1;
        chk("p_iready", 32'(iready1), 32'd1);
        chk("p_idata", idata1, 32'h13);
        tick();
        ivalid1 = 1'b0; mready1 = 1'b0;

        // Watchdog on u0: load that never completes
        tick();
        dvalid = 1'b1; daddr = 32'h3000; mrdata = 32'h77;
        tick();
        chk("t_mvalid", 32'(mvalid), 32'd1);
        tick();
        tick();
        chk("t_dready_c3", 32'(dready), 32'd0);
        tick();
        chk("t_dready_c4", 32'(dready), 32'd1);
        chk("t_drdata", drdata, 32'd0);
        chk("t_bus_err_pre", 32'(bus_err), 32'd0);
        tick();
        dvalid = 1'b0;
        #1;
        chk("t_bus_err", 32'(bus_err), 32'd1);
        chk("t_err_addr", err_addr, 32'h3000);
        chk("t_mvalid_done", 32'(mvalid), 32'd0);
        chk("t_dready_done", 32'(dready), 32'd0);

        // Second timeout with err_clr in the same cycle
        tick();
        dvalid = 1'b1; daddr = 32'h3100;
        tick();
        tick();
        tick();
        tick();
        err_clr = 1'b1;
        #1;
        chk("t2_dready", 32'(dready), 32'd1);
        tick();
        err_clr = 1'b0; dvalid = 1'b0;
        #1;
        chk("t2_bus_err_kept", 32'(bus_err), 32'd1);
        chk("t2_err_addr", err_addr, 32'h3100);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        chk("clr_bus_err", 32'(bus_err), 32'd0);
        chk("clr_err_addr_hold", err_addr, 32'h3100);

        // Make bus_err sticky again, then assert reset mid-transaction
        tick();
        dvalid = 1'b1; daddr = 32'h3200;
        repeat (5) tick();
        dvalid = 1'b0;
        chk("r_bus_err_pre", 32'(bus_err), 32'd1);
        tick();
        dvalid = 1'b1; daddr = 32'h700;
        tick();
        chk("r_busy", 32'(mvalid), 32'd1);
        chk("r_grant_pre", 32'(grant), 32'd1);
        #2;
        reset = 1'b0; mready = 1'b1;
        #1;
        chk("r_mvalid", 32'(mvalid), 32'd0);
        chk("r_grant", 32'(grant), 32'd0);
        chk("r_bus_err", 32'(bus_err), 32'd0);
        chk("r_no_ready", {30'd0, iready, dready}, 32'd0);
        #2;
        mready = 1'b0; reset = 1'b1;
        tick();
        chk("r_regrant", 32'(mvalid), 32'd1);
        chk("r_regrant_owner", 32'(grant), 32'd1);
        chk("r_regrant_addr", maddr, 32'h700);
        mready = 1'b1; mrdata = 32'hBEEF;
        #1;
        chk("r_dready", 32'(dready), 32'd1);
        chk("r_drdata", drdata, 32'hBEEF);
        tick();
        dvalid = 1'b0; mready = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
